// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: NOP control encoding,
// holding-state enum, and the field layout of the ID/EX payload.
package pipe_pkg;

   localparam int PAYLOAD_W_DEF = 128;
   localparam int CTRL_W_DEF    = 9;
   localparam int PERF_W_DEF    = 16;

   // All-zero control decodes as a NOP/bubble in every downstream stage.
   localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

   // Holding state of a stage register; the encoding doubles as occupancy.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_e;

   // ID/EX payload field types.
   typedef logic [31:0] rd_data_t;
   typedef logic [31:0] lw_offset_t;
   typedef logic [15:0] ic_fields_t;
   typedef logic [4:0]  reg_num_t;

   // ID/EX payload layout; 32+32+32+16+5+5+5+1 = 128 bits.
   typedef struct packed {
      rd_data_t   rd1;
      rd_data_t   rd2;
      lw_offset_t lw_offset;
      ic_fields_t ic;
      reg_num_t   rs;
      reg_num_t   rt;
      reg_num_t   rd;
      logic       check_lw;
   } id_ex_payload_t;

   // Number of entries held in a given state.
   function automatic logic [1:0] occupancy_of(input stage_state_e st);
      unique case (st)
         EMPTY:   occupancy_of = 2'd0;
         ONE:     occupancy_of = 2'd1;
         FULL:    occupancy_of = 2'd2;
         default: occupancy_of = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the optional stage performance counters.
module pipe_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Count up on inc, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// flush-to-bubble and asynchronous active-low reset.
// Optional performance counters (stall_cycles, flush_count) are built only
// when the macro PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int PAYLOAD_W = 128,
   parameter int CTRL_W    = 9,
   parameter int PERF_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CTRL_W-1:0]    in_ctrl,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CTRL_W-1:0]    out_ctrl,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [1:0]           occupancy
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [PERF_W-1:0]    stall_cycles,
   output logic [PERF_W-1:0]    flush_count
`endif
);

   // Reject meaningless widths at elaboration time.
   if (PAYLOAD_W < 1 || CTRL_W < 1 || PERF_W < 1) begin : g_bad_width
      $error("pipe_stage_reg: PAYLOAD_W, CTRL_W and PERF_W must be >= 1");
   end

   stage_state_e state, state_nxt;

   logic [CTRL_W-1:0]    main_ctrl, skid_ctrl;
   logic [PAYLOAD_W-1:0] main_payload, skid_payload;

   logic in_xfer, out_xfer;
   logic load_main_in, load_main_skid, load_skid;

   // in_ready and out_valid come straight from the state register, so
   // neither depends combinationally on the opposite side's handshake.
   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign occupancy = occupancy_of(state);

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   // Main register feeds the outputs; control is forced to NOP while empty,
   // payload keeps its last value.
   assign out_ctrl    = out_valid ? main_ctrl : CTRL_W'(CTRL_NOP);
   assign out_payload = main_payload;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and register load selects; flush beats any transfer.
   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_xfer) begin
                  state_nxt    = ONE;
                  load_main_in = 1'b1;
               end
            end
            ONE: begin
               unique case ({in_xfer, out_xfer})
                  2'b11: begin
                     state_nxt    = ONE;
                     load_main_in = 1'b1;
                  end
                  2'b10: begin
                     state_nxt = FULL;
                     load_skid = 1'b1;
                  end
                  2'b01: state_nxt = EMPTY;
                  default: state_nxt = ONE;
               endcase
            end
            FULL: begin
               if (out_xfer) begin
                  state_nxt      = ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // Main entry: loads from input or promotes the skid entry (FIFO order).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_ctrl    <= '0;
         main_payload <= '0;
      end else if (load_main_in) begin
         main_ctrl    <= in_ctrl;
         main_payload <= in_payload;
      end else if (load_main_skid) begin
         main_ctrl    <= skid_ctrl;
         main_payload <= skid_payload;
      end
   end

   // Skid entry: catches the incoming entry while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_ctrl    <= '0;
         skid_payload <= '0;
      end else if (load_skid) begin
         skid_ctrl    <= in_ctrl;
         skid_payload <= in_payload;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   pipe_sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (out_valid && !out_ready),
      .count (stall_cycles)
   );

   pipe_sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush),
      .count (flush_count)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
// Perf-counter checks are compiled only with PIPE_STAGE_PERF_EN.
module tb_pipe_stage_reg;

   localparam int PW = 128;
   localparam int CW = 9;
   localparam int FW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_ctrl;
   logic [PW-1:0] in_payload;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_ctrl;
   logic [PW-1:0] out_payload;
   logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
   logic [FW-1:0] stall_cycles;
   logic [FW-1:0] flush_count;
`endif

   int checks = 0;
   int errors = 0;

   pipe_stage_reg #(.PAYLOAD_W(PW), .CTRL_W(CW), .PERF_W(FW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_ctrl     (in_ctrl),
      .in_payload  (in_payload),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ctrl    (out_ctrl),
      .out_payload (out_payload),
      .occupancy   (occupancy)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cycles(stall_cycles),
      .flush_count (flush_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: a bounded FIFO of depth 2 ----------------
   typedef struct {
      logic [CW-1:0] ctrl;
      logic [PW-1:0] payload;
   } ent_t;

   ent_t          q[$];
   logic [PW-1:0] m_last;
   longint        m_stall;
   longint        m_flush;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_last  = '0;
         m_stall = 0;
         m_flush = 0;
      end else begin
         bit acc_in, acc_out;
         acc_in  = in_valid && (q.size() < 2);
         acc_out = out_ready && (q.size() > 0);
         if (q.size() > 0) m_last = q[0].payload;
         if (q.size() > 0 && !out_ready) m_stall++;
         if (flush) begin
            m_flush++;
            q.delete();
         end else begin
            if (acc_out) void'(q.pop_front());
            if (acc_in) q.push_back('{ctrl: in_ctrl, payload: in_payload});
         end
      end
   end

   // Compare every cycle on the falling edge, away from the active edge.
   always @(negedge clk) begin
      check("m_out_valid", PW'(out_valid), PW'(q.size() > 0));
      check("m_in_ready",  PW'(in_ready),  PW'(q.size() < 2));
      check("m_occupancy", PW'(occupancy), PW'(q.size()));
      check("m_out_ctrl",  PW'(out_ctrl),  (q.size() > 0) ? PW'(q[0].ctrl) : '0);
      check("m_out_payload", out_payload, (q.size() > 0) ? q[0].payload : m_last);
`ifdef PIPE_STAGE_PERF_EN
      check("m_stall_cycles", PW'(stall_cycles), PW'((m_stall > 65535) ? 65535 : m_stall));
      check("m_flush_count",  PW'(flush_count),  PW'((m_flush > 65535) ? 65535 : m_flush));
`endif
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [PW-1:0] p, input logic rdy, input logic fl);
      in_valid   = v;
      in_payload = p;
      in_ctrl    = p[CW-1:0] | 9'h100;
      out_ready  = rdy;
      flush      = fl;
   endtask

   logic [PW-1:0] mix_pat;

   initial begin
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
      #1;
      check("rst_out_valid", PW'(out_valid), '0);
      check("rst_in_ready",  PW'(in_ready),  PW'(1));
      check("rst_occupancy", PW'(occupancy), '0);
      check("rst_out_payload", out_payload, '0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Streaming: 0x1..0xA with no back-pressure, one cycle latency.
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, PW'(i), 1'b1, 1'b0);
         step();
         check("stream_payload", out_payload, PW'(i));
         check("stream_valid", PW'(out_valid), PW'(1));
      end

      // Bubble: no input for 3 cycles, payload holds 0xA, control is NOP.
      drive(1'b0, PW'(16'hDEAD), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("bubble_ctrl", PW'(out_ctrl), '0);
         check("bubble_payload", out_payload, PW'(10));
      end

      // Back-pressure: 0x11, 0x22 held while out_ready=0.
      drive(1'b1, PW'(8'h11), 1'b0, 1'b0);
      step();
      drive(1'b1, PW'(8'h22), 1'b0, 1'b0);
      step();
      check("bp_occupancy", PW'(occupancy), PW'(2));
      check("bp_in_ready", PW'(in_ready), '0);
      check("bp_head", out_payload, PW'(8'h11));
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
      check("bp_second", out_payload, PW'(8'h22));
      check("bp_ready_back", PW'(in_ready), PW'(1));
      step();
      check("bp_drained", PW'(out_valid), '0);

      // Flush while full, with a simultaneous input 0x33.
      drive(1'b1, PW'(8'h44), 1'b0, 1'b0);
      step();
      drive(1'b1, PW'(8'h55), 1'b0, 1'b0);
      step();
      drive(1'b1, PW'(8'h33), 1'b0, 1'b1);
      step();
      check("fl_occupancy", PW'(occupancy), '0);
      check("fl_out_valid", PW'(out_valid), '0);
      check("fl_out_ctrl", PW'(out_ctrl), '0);
      check("fl_in_ready", PW'(in_ready), PW'(1));
      check("fl_payload_hold", out_payload, PW'(8'h44));
      // Flush with one held entry and an accepted input 0x66.
      drive(1'b1, PW'(8'h60), 1'b0, 1'b0);
      step();
      drive(1'b1, PW'(8'h66), 1'b1, 1'b1);
      step();
      check("fl1_out_valid", PW'(out_valid), '0);
      drive(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("fl_nothing_leaks", PW'(out_valid), '0);
      end

      // Mixed traffic pattern, checked by the model every cycle.
      mix_pat = 128'h9C3A_51E7_0F2D_B846_7A13_C5E9_2B60_D48F;
      for (int i = 0; i < 40; i++) begin
         drive(mix_pat[i], PW'(32'hA000_0000 + i), mix_pat[i+40], (i % 13) == 12);
         step();
      end

      // Asynchronous reset mid-stream with occupancy 2.
      drive(1'b1, PW'(8'h77), 1'b0, 1'b0);
      step();
      drive(1'b1, PW'(8'h88), 1'b0, 1'b0);
      step();
      check("pre_rst_occupancy", PW'(occupancy), PW'(2));
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", PW'(out_valid), '0);
      check("arst_out_ctrl", PW'(out_ctrl), '0);
      check("arst_occupancy", PW'(occupancy), '0);
      check("arst_in_ready", PW'(in_ready), PW'(1));
      check("arst_payload", out_payload, '0);
      drive(1'b0, '0, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
      step();

`ifdef PIPE_STAGE_PERF_EN
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, 1'b1, 1'b1);
         step();
         drive(1'b0, '0, 1'b1, 1'b0);
         step();
      end
      check("perf_flush_count", PW'(flush_count), PW'(3));
      drive(1'b1, PW'(8'h99), 1'b0, 1'b0);
      step();
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (70000) @(posedge clk);
      #1;
      check("perf_stall_sat", PW'(stall_cycles), PW'(16'hFFFF));
`endif

      drive(1'b0, '0, 1'b1, 1'b0);
      step();
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised ID/EX-style pipeline stage register. Replaces bare always-latching stage registers.
- Adds a valid/ready handshake, a 2-entry skid buffer for back-pressure, flush-to-bubble, and asynchronous reset.
- Sits between any two pipeline stages: ID->EX, EX->MEM, MEM->WB.
- The payload carries operand data, immediates, instruction fields and register numbers; the control field carries decoded control signals.

Parameters:
- PAYLOAD_W, 128, width of the data payload (e.g. RD1 + RD2 + offset + fields).
- CTRL_W, 9, width of the control-signal field; all-zero encodes a NOP/bubble.
- PERF_W, 16, width of the optional performance counters.

Ports:
- clk  input  1  stage clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has a valid entry.
- in_ready  output  1  stage can accept an entry this cycle.
- in_ctrl  input  CTRL_W  upstream control signals.
- in_payload  input  PAYLOAD_W  upstream payload.
- flush  input  1  synchronous kill of all held and incoming entries.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head entry.
- out_ctrl  output  CTRL_W  head control; forced to 0 when out_valid=0.
- out_payload  output  PAYLOAD_W  head payload.
- occupancy  output  2  number of held entries (0..2).
- stall_cycles  output  PERF_W  present only with PIPE_STAGE_PERF_EN.
- flush_count  output  PERF_W  present only with PIPE_STAGE_PERF_EN.

Behaviour:
- Clock and reset:
  - One clock (clk).
  - rst_n is asynchronous and active-low.
  - While rst_n=0: occupancy=0, out_valid=0, in_ready=1, out_ctrl=0, out_payload=0, and both entries cleared.
  - Reset mid-transfer discards all entries.
- Handshake:
  - Transfer in when in_valid && in_ready at the rising edge.
  - Transfer out when out_valid && out_ready.
  - in_valid must not depend on in_ready.
- Storage:
  - main reg drives the outputs directly.
  - skid reg catches one entry when downstream stalls.
  - in_ready is registered: in_ready = (state != FULL).
- States:
  - EMPTY (occupancy 0): in xfer -> ONE (load main).
  - ONE (occupancy 1):
    - in && out -> ONE (main <= in).
    - in && !out -> FULL (skid <= in).
    - !in && out -> EMPTY.
    - neither -> hold.
  - FULL (occupancy 2): in_ready=0.
    - out xfer -> ONE (main <= skid).
    - otherwise hold.
- Latency and throughput:
  - Latency is 1 cycle: an entry accepted at edge N is visible at out_* after edge N.
  - Throughput is 1 entry/cycle with no back-pressure.
- Ordering: FIFO order is always preserved; the skid entry never overtakes main.
- Flush:
  - flush=1 at an edge -> state EMPTY, in_ready=1 next cycle.
  - An input handshake in the same cycle is discarded; upstream sees it as accepted.
  - flush has priority over any simultaneous in/out transfer.
  - out_payload holds its last value; out_ctrl=0.
- Bubble: whenever out_valid=0, out_ctrl=0, so downstream control decodes as NOP regardless of payload.
- Widths: no arithmetic on payload or control; fields pass through bit-exact.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cycles increments each cycle out_valid && !out_ready.
  - flush_count increments on each cycle flush=1.
  - Both are PERF_W wide and saturate at all-ones (no wrap).
  - Both reset to 0 on rst_n=0.
- Undefined: the counters and both ports are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - CTRL_NOP constant (all-zero control).
  - The state enum {EMPTY, ONE, FULL}.
  - Typedefs for the ID/EX payload fields: rd1, rd2, lw_offset, ic fields, register numbers, check_lw.
- Natural sub-module: pipe_sat_counter (saturating counter, width PERF_W), instantiated twice under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset: assert rst_n=0 mid-stream with occupancy=2 -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=1 immediately, without waiting for clk.
- Streaming: out_ready=1, in_valid=1 with payload 0x1..0xA over 10 cycles -> out_payload shows 0x1..0xA one cycle later, in order, with no gaps.
- Back-pressure: out_ready=0 while in_valid=1 carrying 0x11 then 0x22 -> occupancy=2, in_ready=0; then release out_ready -> 0x11 then 0x22 output, and in_ready returns to 1 after the first out transfer.
- Flush: with occupancy=2, flush=1 and in_valid=1 (payload 0x33) in the same cycle -> next cycle occupancy=0, out_valid=0, out_ctrl=0; 0x33 never appears at the output.
- Bubble: in_valid=0 for 3 cycles with out_ready=1 -> out_ctrl=0 for those cycles while out_payload holds its last value.
- Perf (PIPE_STAGE_PERF_EN): hold out_ready=0 with out_valid=1 for 70000 cycles -> stall_cycles=16'hFFFF saturated; 3 flush pulses -> flush_count=3.
